// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - FP format helpers, class bit indices and operand packing shared by the FP blocks.
package fp_pkg;

  typedef enum logic [1:0] {FP16, FP32, FP64} fp_format_e;

  localparam int CLASS_NUM      = 10;
  localparam int CLASS_NEG_INF  = 0;
  localparam int CLASS_NEG_NORM = 1;
  localparam int CLASS_NEG_SUB  = 2;
  localparam int CLASS_NEG_ZERO = 3;
  localparam int CLASS_POS_ZERO = 4;
  localparam int CLASS_POS_SUB  = 5;
  localparam int CLASS_POS_NORM = 6;
  localparam int CLASS_POS_INF  = 7;
  localparam int CLASS_SNAN     = 8;
  localparam int CLASS_QNAN     = 9;

  typedef logic [CLASS_NUM-1:0] classmask_e;

  function automatic int exp_bits(input fp_format_e f);
    case (f)
      FP16:    return 5;
      FP64:    return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int man_bits(input fp_format_e f);
    case (f)
      FP16:    return 10;
      FP64:    return 52;
      default: return 23;
    endcase
  endfunction

  function automatic int fp_width(input fp_format_e f);
    return 1 + exp_bits(f) + man_bits(f);
  endfunction

  // Fibonacci step, taps 64,63,61,60; state shifts toward the MSB.
  function automatic logic [63:0] lfsr64_next(input logic [63:0] r);
    return {r[62:0], r[63] ^ r[62] ^ r[60] ^ r[59]};
  endfunction

  // Fields are masked to their widths, so all-ones can be passed as '1.
  function automatic logic [63:0] fp_make(input logic sign, input logic [63:0] exp,
                                          input logic [63:0] man, input fp_format_e f);
    int eb;
    int mb;
    logic [63:0] emask;
    logic [63:0] mmask;
    eb    = exp_bits(f);
    mb    = man_bits(f);
    emask = (64'd1 << eb) - 64'd1;
    mmask = (64'd1 << mb) - 64'd1;
    return (64'(sign) << (eb + mb)) | ((exp & emask) << mb) | (man & mmask);
  endfunction

endpackage

// File: rtl/fp_lfsr64.sv
// rtl/fp_lfsr64.sv - 64-bit payload LFSR that advances only when stepped.
module fp_lfsr64
  import fp_pkg::*;
#(
  parameter logic [63:0] SEED = 64'h1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        step_i,
  output logic [63:0] state_o
);

  localparam logic [63:0] SEED_EFF = (SEED == 64'd0) ? 64'd1 : SEED;

  logic [63:0] r_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= SEED_EFF;
    end else if (step_i) begin
      r_q <= lfsr64_next(r_q);
    end
  end

  assign state_o = r_q;

endmodule

// File: rtl/fp_class_gen.sv
// rtl/fp_class_gen.sv - Emits one operand per requested FP class over a valid/ready stream.
module fp_class_gen
  import fp_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT = FP32,
  parameter logic [63:0] SEED      = 64'h1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  classmask_e                       mask_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [fp_width(FP_FORMAT)-1:0]   value_o,
  output classmask_e                       class_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int FP_WIDTH = fp_width(FP_FORMAT);
  localparam int EXP_BITS = exp_bits(FP_FORMAT);
  localparam int MAN_BITS = man_bits(FP_FORMAT);

  typedef enum logic [1:0] {IDLE, EMIT, FIN} state_e;

  state_e                state_q, state_d;
  classmask_e            pend_q, pend_d, pick_d, class_q;
  logic [FP_WIDTH-1:0]   value_q;
  logic [63:0]           r_q, r_d;
  logic                  hs;

  fp_lfsr64 #(.SEED(SEED)) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .step_i  (hs),
    .state_o (r_q)
  );

  assign hs  = (state_q == EMIT) && ready_i;
  assign r_d = hs ? lfsr64_next(r_q) : r_q;

  function automatic logic [FP_WIDTH-1:0] build(input classmask_e pick, input logic [63:0] r);
    logic [EXP_BITS-1:0] re, norm_exp;
    logic [MAN_BITS-1:0] rm, sub_man;
    logic [MAN_BITS-2:0] nan_low;
    logic [63:0]         w;
    re       = r[63 -: EXP_BITS];
    rm       = r[MAN_BITS-1:0];
    // Clamp payload fields so the operand cannot slip into a neighbouring class.
    norm_exp = (re == '0) ? EXP_BITS'(1) : ((re == '1) ? ~EXP_BITS'(1) : re);
    sub_man  = (rm == '0) ? MAN_BITS'(1) : rm;
    nan_low  = (rm[MAN_BITS-2:0] == '0) ? (MAN_BITS-1)'(1) : rm[MAN_BITS-2:0];
    w = '0;
    if (pick[CLASS_NEG_INF])  w = fp_make(1'b1, '1, '0, FP_FORMAT);
    if (pick[CLASS_NEG_NORM]) w = fp_make(1'b1, 64'(norm_exp), 64'(rm), FP_FORMAT);
    if (pick[CLASS_NEG_SUB])  w = fp_make(1'b1, '0, 64'(sub_man), FP_FORMAT);
    if (pick[CLASS_NEG_ZERO]) w = fp_make(1'b1, '0, '0, FP_FORMAT);
    if (pick[CLASS_POS_ZERO]) w = fp_make(1'b0, '0, '0, FP_FORMAT);
    if (pick[CLASS_POS_SUB])  w = fp_make(1'b0, '0, 64'(sub_man), FP_FORMAT);
    if (pick[CLASS_POS_NORM]) w = fp_make(1'b0, 64'(norm_exp), 64'(rm), FP_FORMAT);
    if (pick[CLASS_POS_INF])  w = fp_make(1'b0, '1, '0, FP_FORMAT);
    if (pick[CLASS_SNAN])     w = fp_make(r[62], '1, 64'({1'b0, nan_low}), FP_FORMAT);
    if (pick[CLASS_QNAN])     w = fp_make(r[62], '1, 64'({1'b1, rm[MAN_BITS-2:0]}), FP_FORMAT);
    return w[FP_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          pend_d  = mask_i;
          state_d = (mask_i == '0) ? FIN : EMIT;
        end
      end
      EMIT: begin
        if (ready_i) begin
          pend_d = pend_q & (pend_q - classmask_e'(1));
          if (pend_d == '0) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pick_d = pend_d & (~pend_d + classmask_e'(1));
  end

  // Outputs are computed from next-state values so they line up with valid_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pend_q  <= '0;
      class_q <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      class_q <= (state_d == EMIT) ? pick_d : '0;
      value_q <= (state_d == EMIT) ? build(pick_d, r_d) : '0;
    end
  end

  assign valid_o = (state_q == EMIT);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == FIN);
  assign class_o = class_q;
  assign value_o = value_q;

endmodule

// File: tb/tb_fp_class_gen.sv
// tb/tb_fp_class_gen.sv - Directed self-checking bench for fp_class_gen.
module tb_fp_class_gen;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst, start, ready;
  logic [9:0] mask;

  logic        a_valid, a_busy, a_done;
  logic [31:0] a_value;
  logic [9:0]  a_class;
  logic        z_valid, z_busy, z_done;
  logic [31:0] z_value;
  logic [9:0]  z_class;
  logic        h_valid, h_busy, h_done;
  logic [31:0] h_value;
  logic [9:0]  h_class;
  logic        d_valid, d_busy, d_done;
  logic [63:0] d_value;
  logic [9:0]  d_class;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fp_class_gen #(.FP_FORMAT(FP32), .SEED(64'h1)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mask_i(mask), .valid_o(a_valid),
    .ready_i(ready), .value_o(a_value), .class_o(a_class), .busy_o(a_busy), .done_o(a_done));
  fp_class_gen #(.FP_FORMAT(FP32), .SEED(64'h0)) u_z (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mask_i(mask), .valid_o(z_valid),
    .ready_i(ready), .value_o(z_value), .class_o(z_class), .busy_o(z_busy), .done_o(z_done));
  fp_class_gen #(.FP_FORMAT(FP32), .SEED(64'hFF00_0000_0000_0000)) u_h (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mask_i(mask), .valid_o(h_valid),
    .ready_i(ready), .value_o(h_value), .class_o(h_class), .busy_o(h_busy), .done_o(h_done));
  fp_class_gen #(.FP_FORMAT(FP64), .SEED(64'h1)) u_d (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mask_i(mask), .valid_o(d_valid),
    .ready_i(ready), .value_o(d_value), .class_o(d_class), .busy_o(d_busy), .done_o(d_done));

  function automatic logic [9:0] classify(input logic [63:0] v, input int eb, input int mb);
    logic        s;
    logic [63:0] e, m;
    int          idx;
    s = v[eb+mb];
    e = (v >> mb) & ((64'd1 << eb) - 64'd1);
    m = v & ((64'd1 << mb) - 64'd1);
    if (e == ((64'd1 << eb) - 64'd1)) begin
      if (m == 64'd0) idx = s ? 0 : 7;
      else            idx = ((m >> (mb - 1)) & 64'd1) != 64'd0 ? 9 : 8;
    end else if (e == 64'd0) begin
      if (m == 64'd0) idx = s ? 3 : 4;
      else            idx = s ? 2 : 5;
    end else begin
      idx = s ? 1 : 6;
    end
    return 10'd1 << idx;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_req(input logic [9:0] m);
    @(negedge clk);
    start = 1'b1;
    mask  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if ({a_valid, a_busy, a_done} !== 3'b000) $display("FAIL reset_ctrl got %b exp 000", {a_valid, a_busy, a_done}); else passed++;
    checks++; if (a_value !== 32'h0) $display("FAIL reset_value got %h exp 00000000", a_value); else passed++;
    checks++; if (a_class !== 10'h0) $display("FAIL reset_class got %h exp 000", a_class); else passed++;
  endtask

  task automatic test_all_classes();
    logic [31:0] e [10];
    e = '{32'hFF800000, 32'h80800002, 32'h80000004, 32'h80000000, 32'h00000000,
          32'h00000020, 32'h00800040, 32'h7F800000, 32'h7F800100, 32'h7FC00200};
    do_reset();
    ready = 1'b1;
    start_req(10'h3FF);
    for (int i = 0; i < 10; i++) begin
      checks++; if (a_valid !== 1'b1) $display("FAIL all_valid[%0d] got %b exp 1", i, a_valid); else passed++;
      checks++; if (a_value !== e[i]) $display("FAIL all_value[%0d] got %h exp %h", i, a_value, e[i]); else passed++;
      checks++; if (a_class !== (10'd1 << i)) $display("FAIL all_class[%0d] got %h exp %h", i, a_class, 10'd1 << i); else passed++;
      checks++; if (classify(64'(a_value), 8, 23) !== a_class) $display("FAIL all_rt32[%0d] got %h exp %h", i, classify(64'(a_value), 8, 23), a_class); else passed++;
      checks++; if (d_class !== (10'd1 << i)) $display("FAIL fp64_class[%0d] got %h exp %h", i, d_class, 10'd1 << i); else passed++;
      checks++; if (classify(d_value, 11, 52) !== (10'd1 << i)) $display("FAIL fp64_rt[%0d] got %h exp %h", i, classify(d_value, 11, 52), 10'd1 << i); else passed++;
      @(negedge clk);
    end
    checks++; if ({a_done, a_valid} !== 2'b10) $display("FAIL all_done got %b exp 10", {a_done, a_valid}); else passed++;
    @(negedge clk);
    checks++; if ({a_busy, a_done} !== 2'b00) $display("FAIL all_idle got %b exp 00", {a_busy, a_done}); else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0;
    start_req(10'h240);
    for (int c = 0; c < 4; c++) begin
      checks++; if (a_value !== 32'h00800001 || a_class !== 10'h040 || a_valid !== 1'b1)
        $display("FAIL bp_hold[%0d] got %h/%h/%b exp 00800001/040/1", c, a_value, a_class, a_valid); else passed++;
      if (c == 3) ready = 1'b1;
      @(negedge clk);
    end
    checks++; if (a_value !== 32'h7FC00002 || a_class !== 10'h200) $display("FAIL bp_qnan got %h/%h exp 7fc00002/200", a_value, a_class); else passed++;
    checks++; if (a_value[30:22] !== 9'h1FF) $display("FAIL bp_qnan_bits got %h exp 1ff", a_value[30:22]); else passed++;
    @(negedge clk);
    checks++; if (a_done !== 1'b1) $display("FAIL bp_done got %b exp 1", a_done); else passed++;
  endtask

  task automatic test_empty();
    ready = 1'b1;
    start_req(10'h000);
    checks++; if ({a_done, a_valid, a_busy} !== 3'b101) $display("FAIL empty_c1 got %b exp 101", {a_done, a_valid, a_busy}); else passed++;
    @(negedge clk);
    checks++; if ({a_done, a_valid, a_busy} !== 3'b000) $display("FAIL empty_c2 got %b exp 000", {a_done, a_valid, a_busy}); else passed++;
  endtask

  task automatic test_clamp();
    logic [9:0]  m  [6];
    logic [31:0] ez [6];
    logic [31:0] eh [6];
    m  = '{10'h002, 10'h040, 10'h004, 10'h020, 10'h100, 10'h200};
    ez = '{32'h80800001, 32'h00800001, 32'h80000001, 32'h00000001, 32'h7F800001, 32'h7FC00001};
    eh = '{32'hFF000000, 32'h7F000000, 32'h80000001, 32'h00000001, 32'hFF800001, 32'hFFC00000};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      ready = 1'b1;
      start_req(m[i]);
      checks++; if (z_value !== ez[i]) $display("FAIL clamp_lo[%0d] got %h exp %h", i, z_value, ez[i]); else passed++;
      checks++; if (h_value !== eh[i]) $display("FAIL clamp_hi[%0d] got %h exp %h", i, h_value, eh[i]); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic run_stream(output logic [31:0] rec [$]);
    rec = {};
    do_reset();
    ready = 1'b0;
    start_req(10'h3FF);
    for (int c = 0; c < 40; c++) begin
      ready = (c % 3) != 0;
      if (a_valid && ready) rec.push_back(a_value);
      @(negedge clk);
    end
  endtask

  task automatic test_determinism();
    logic [31:0] r1 [$];
    logic [31:0] r2 [$];
    logic [31:0] e  [10];
    e = '{32'hFF800000, 32'h80800002, 32'h80000004, 32'h80000000, 32'h00000000,
          32'h00000020, 32'h00800040, 32'h7F800000, 32'h7F800100, 32'h7FC00200};
    run_stream(r1);
    run_stream(r2);
    checks++; if (r1.size() != 10 || r2.size() != 10) $display("FAIL det_len got %0d/%0d exp 10", r1.size(), r2.size()); else passed++;
    for (int i = 0; i < 10 && i < r1.size() && i < r2.size(); i++) begin
      checks++; if (r1[i] !== r2[i] || r1[i] !== e[i]) $display("FAIL det_val[%0d] got %h/%h exp %h", i, r1[i], r2[i], e[i]); else passed++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    ready = 1'b1;
    start_req(10'h3FF);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({a_valid, a_busy, a_done} !== 3'b000 || a_value !== 32'h0 || a_class !== 10'h0)
      $display("FAIL arst_now got %b/%h/%h exp 000/0/0", {a_valid, a_busy, a_done}, a_value, a_class); else passed++;
    @(negedge clk);
    checks++; if (a_done !== 1'b0) $display("FAIL arst_nodone got %b exp 0", a_done); else passed++;
    rst = 1'b0;
    start_req(10'h010);
    checks++; if (a_valid !== 1'b1 || a_value !== 32'h0 || a_class !== 10'h010)
      $display("FAIL arst_restart got %b/%h/%h exp 1/0/010", a_valid, a_value, a_class); else passed++;
    @(negedge clk);
    checks++; if (a_done !== 1'b1) $display("FAIL arst_done got %b exp 1", a_done); else passed++;
  endtask

  task automatic test_ignored_start();
    do_reset();
    ready = 1'b0;
    start_req(10'h003);
    start = 1'b1;
    mask  = 10'h3FF;
    @(negedge clk);
    start = 1'b0;
    checks++; if (a_class !== 10'h001 || a_valid !== 1'b1) $display("FAIL ign_emit got %h/%b exp 001/1", a_class, a_valid); else passed++;
    ready = 1'b1;
    @(negedge clk);
    checks++; if (a_class !== 10'h002) $display("FAIL ign_second got %h exp 002", a_class); else passed++;
    @(negedge clk);
    checks++; if (a_done !== 1'b1) $display("FAIL ign_done got %b exp 1", a_done); else passed++;
    start = 1'b1;
    mask  = 10'h3FF;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({a_busy, a_valid} !== 2'b00) $display("FAIL ign_fin got %b exp 00", {a_busy, a_valid}); else passed++;
    @(negedge clk);
    checks++; if ({a_busy, a_valid} !== 2'b00) $display("FAIL ign_idle got %b exp 00", {a_busy, a_valid}); else passed++;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    mask  = 10'h0;
    #12 rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_all_classes();
    test_backpressure();
    test_empty();
    test_clamp();
    test_determinism();
    test_async_reset();
    test_ignored_start();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_class_gen.md
# fp_class_gen

Class-directed operand generator, the inverse of the FP classifier. It accepts a 10-bit class mask and emits, over a valid/ready stream, one operand per set mask bit. Each operand belongs exactly to its requested class (±inf, ±normal, ±subnormal, ±0, sNaN, qNaN). Payload bits come from an internal LFSR. It sits in the FPU verification/self-test path and feeds operand queues in front of the arithmetic units. Output operands round-trip through the classifier to the same one-hot class.

## Interface
- `FP_FORMAT`, default `FP32`: operand format (`fp_format_e`). Fixes `FP_WIDTH`, `EXP_BITS` and `MAN_BITS` through `fp_pkg` functions.
- `SEED`, default `64'h1`: LFSR reset value. A value of 0 is replaced by 1.
- `clk_i` in, 1: clock.
- `rst_i` in, 1: reset, asynchronous, active-high.
- `start_i` in, 1: request strobe. Sampled only in IDLE.
- `mask_i` in, 10 (`classmask_e`): requested classes. Bit order matches the classifier (0 = −inf … 9 = qNaN).
- `valid_o` out, 1: `value_o`/`class_o` are valid.
- `ready_i` in, 1: consumer accepts the current value.
- `value_o` out, `FP_WIDTH`: generated operand.
- `class_o` out, 10: one-hot class of `value_o`.
- `busy_o` out, 1: state ≠ IDLE.
- `done_o` out, 1: one-cycle pulse when the request completes.

## Operation
- **FSM states:** IDLE, EMIT, FIN.
  - IDLE & `start_i`: `pend <= mask_i`. If `mask_i == 0`, go to FIN; otherwise go to EMIT.
  - EMIT: current class is the lowest set bit of `pend`. On `valid_o & ready_i`, that bit clears. If the remaining `pend` is 0, go to FIN.
  - FIN: `done_o = 1` for one cycle, then go to IDLE. `start_i` is ignored in FIN and in EMIT.
- `valid_o = (state == EMIT)`. `class_o` is the one-hot lowest bit of `pend` in EMIT and 0 otherwise.
- **LFSR:** 64-bit Fibonacci LFSR, taps 64,63,61,60. Let `r` be its state.
  - It steps exactly once per handshake, never otherwise.
  - Fields: `rm = r[MAN_BITS-1:0]`, `re = r[63 -: EXP_BITS]`, `rs = r[62]`.
- **Operand construction** (sign, exp, man):
  - −inf / +inf: 1 / 0, all-ones, 0.
  - ±normal: sign per class, exp = `re`, man = `rm`. If `re == 0` substitute 1. If `re` is all-ones substitute all-ones−1.
  - ±subnormal: sign per class, exp = 0, man = `rm`. If `rm == 0` substitute 1.
  - ±0: sign per class, exp = 0, man = 0.
  - sNaN: sign = `rs`, exp all-ones, man MSB = 0, lower bits = `rm[MAN_BITS-2:0]`. If those lower bits are 0, substitute 1.
  - qNaN: sign = `rs`, exp all-ones, man MSB = 1, lower bits = `rm[MAN_BITS-2:0]`.
- `value_o` is a registered output. It is recomputed from `pend`/`r` whenever they change and is 0 outside EMIT.

## Timing
- **Reset values:** `valid_o`, `value_o`, `class_o`, `busy_o`, `done_o` = 0. State = IDLE, `pend` = 0, `r` = SEED (or 1 if SEED is 0).
- **Latency:** `start_i` sampled at edge 0 → `valid_o` high from cycle 1.
- **Throughput:** one operand per cycle while `ready_i` is held high.
- **Full request:** a k-bit mask with `ready_i` high gives `valid_o` for cycles 1..k, `done_o` in cycle k+1, and IDLE in cycle k+2.
- **Empty mask:** `done_o` in cycle 1, with no `valid_o`.
- **Stall:** while `valid_o & !ready_i`, `value_o`, `class_o` and `r` hold stable. `valid_o` never drops without a handshake.
- **Async reset mid-EMIT:** aborts immediately. No `done_o` is issued and all outputs return to their reset values.
- **Next request:** `start_i` in the FIN cycle is dropped, so the earliest next request is sampled in the cycle after `done_o`.

## Structure
- **`fp_pkg`** gains:
  - `CLASS_*` bit-index constants, shared with the classifier.
  - a `fp_make(sign, exp, man)` packing function.
  - `exp_bits()` / `man_bits()` functions, if they are not already present.
- **Sub-module `fp_lfsr64`:** parameter `SEED`; ports `clk_i`, `rst_i`, `step_i`, `state_o`.
- FSM, priority pick and operand mux live in `fp_class_gen`.

## Test plan
- **All classes, FP32, SEED=1:** `mask_i = 10'h3FF`, `ready_i = 1`.
  - Ten consecutive values, in order.
  - Each value fed through `fp_classify` gives a class equal to `class_o`.
  - Value 0 is `0xFF800000`; value 3 is `0x80000000`; value 4 is `0x00000000`; value 7 is `0x7F800000`.
  - `done_o` in cycle 11.
- **Backpressure:** `mask_i = 10'h240` (+normal, qNaN), `ready_i` low for 3 cycles.
  - The +normal value holds stable for 4 cycles, then the qNaN follows.
  - A qNaN `value_o` satisfies `value_o[30:22] == 9'h1FF` (FP32).
- **Empty mask:** `done_o` pulses in cycle 1, `valid_o` never rises, `busy_o` is high for 1 cycle.
- **Reproducibility:**
  - Clamping: force the LFSR state to 0-exponent and all-ones-exponent patterns. ±normal then yields exp 1 and exp 0xFE (FP32). ±subnormal/sNaN with `rm == 0` yields man 1 and never 0.
  - Determinism: two runs with the same SEED and the same handshake pattern give identical streams.
- **Reset and ignored starts:**
  - Assert `rst_i` asynchronously mid-EMIT: outputs are 0 immediately, no `done_o`, and after release a new start works.
  - `start_i` pulsed in EMIT and in FIN is ignored.
- **FP64 (and FP16):** `FP_FORMAT = FP64`, `mask_i = 10'h3FF`. The classifier round-trip matches for all ten values.
